adc_evt_packer: RTL



---
 rtl/adc_pkg.sv | 30 +++
 rtl/adc_out_reg.sv | 35 +++
 rtl/adc_evt_packer.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/adc_pkg.sv
// Shared constants for the ADC event packer: FSM state codes, marker defaults
// and frame field widths.
package adc_pkg;

    localparam int ST_W   = 3;
    localparam int MARK_W = 8;
    localparam int EVT_W  = 16;
    localparam int CHK_W  = 16;
    localparam int TS_W   = 40;
    localparam int SMP_W  = 14;
    localparam int WORD_W = 32;
    localparam int CNT_W  = 12;

    localparam logic [ST_W-1:0] ST_IDLE = 3'd0;
    localparam logic [ST_W-1:0] ST_HDR  = 3'd1;
    localparam logic [ST_W-1:0] ST_TSH  = 3'd2;
    localparam logic [ST_W-1:0] ST_TSL  = 3'd3;
    localparam logic [ST_W-1:0] ST_DATA = 3'd4;
    localparam logic [ST_W-1:0] ST_TRL  = 3'd5;

    localparam logic [MARK_W-1:0] HDR_MARK_DEF = 8'hA5;
    localparam logic [MARK_W-1:0] TRL_MARK_DEF = 8'h5A;

    // Header and trailer share one layout: marker, zero byte, 16-bit field.
    function automatic logic [WORD_W-1:0] mark_word(input logic [MARK_W-1:0] mark,
                                                    input logic [EVT_W-1:0]  field);
        return {mark, 8'h00, field};
    endfunction

endpackage

// File: rtl/adc_out_reg.sv
// Single-entry valid/ready output register: a word is taken whenever the slot
// is empty or being drained, and is held stable until the sink accepts it.
module adc_out_reg #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_push,
    input  logic [W-1:0] i_data,
    input  logic         i_ready,
    output logic         o_valid,
    output logic [W-1:0] o_data,
    output logic         o_load
);

    logic         r_valid;
    logic [W-1:0] r_data;

    assign o_load  = ~r_valid | i_ready;
    assign o_valid = r_valid;
    assign o_data  = r_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else if (o_load) begin
            r_valid <= i_push;
            if (i_push) begin
                r_data <= i_data;
            end
        end
    end

endmodule

// File: rtl/adc_evt_packer.sv
// Packs one triggered event (header, timestamp, NSAMP paired ADC samples, trailer)
// into 32-bit words. Define ADC_EVT_PACKER_CHKSUM_EN to fill the trailer with a sample sum.
module adc_evt_packer
    import adc_pkg::*;
#(
    parameter int                NSAMP    = 1024,
    parameter logic [MARK_W-1:0] HDR_MARK = HDR_MARK_DEF,
    parameter logic [MARK_W-1:0] TRL_MARK = TRL_MARK_DEF
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                trig,
    input  logic [TS_W-1:0]     time_in,
    input  logic [SMP_W-1:0]    fifo1_q,
    input  logic                fifo1_empty,
    output logic                fifo1_rdreq,
    input  logic [SMP_W-1:0]    fifo2_q,
    input  logic                fifo2_empty,
    output logic                fifo2_rdreq,
    output logic [WORD_W-1:0]   out_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic                busy,
    output logic [15:0]         drop_cnt
);

    localparam logic [CNT_W-1:0] NSAMP_L = CNT_W'(NSAMP);

    logic [ST_W-1:0]   r_state;
    logic [TS_W-1:0]   r_ts;
    logic [EVT_W-1:0]  r_evt_cnt;
    logic [CNT_W-1:0]  r_rem;
    logic              r_busy;
    logic              r_trl_sent;
    logic [15:0]       r_drop_cnt;

    logic              w_load;
    logic              w_pop;
    logic              w_push;
    logic [WORD_W-1:0] w_word;
    logic              w_trl_acc;
    logic [CHK_W-1:0]  w_chk;

    // Both FIFOs move in lockstep so sample pairs can never slip.
    assign w_pop = (r_state == ST_DATA) & ~fifo1_empty & ~fifo2_empty
                 & w_load & (r_rem != '0);

    assign w_trl_acc = (r_state == ST_TRL) & r_trl_sent & out_valid & out_ready;

    assign fifo1_rdreq = w_pop;
    assign fifo2_rdreq = w_pop;
    assign busy        = r_busy;
    assign drop_cnt    = r_drop_cnt;

    always_comb begin
        w_push = 1'b0;
        w_word = '0;
        case (r_state)
            ST_HDR: begin
                w_push = w_load;
                w_word = mark_word(HDR_MARK, r_evt_cnt);
            end
            ST_TSH: begin
                w_push = w_load;
                w_word = {24'h0, r_ts[39:32]};
            end
            ST_TSL: begin
                w_push = w_load;
                w_word = r_ts[31:0];
            end
            ST_DATA: begin
                w_push = w_pop;
                w_word = {2'b00, fifo2_q, 2'b00, fifo1_q};
            end
            ST_TRL: begin
                w_push = w_load & ~r_trl_sent;
                w_word = mark_word(TRL_MARK, w_chk);
            end
            default: begin
                w_push = 1'b0;
                w_word = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_ts       <= '0;
            r_evt_cnt  <= '0;
            r_rem      <= '0;
            r_busy     <= 1'b0;
            r_trl_sent <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (trig) begin
                        r_ts      <= time_in;
                        r_evt_cnt <= r_evt_cnt + 16'd1;
                        r_busy    <= 1'b1;
                        r_state   <= ST_HDR;
                    end
                end
                ST_HDR: begin
                    if (w_load) begin
                        r_rem   <= NSAMP_L;
                        r_state <= ST_TSH;
                    end
                end
                ST_TSH: begin
                    if (w_load) begin
                        r_state <= ST_TSL;
                    end
                end
                ST_TSL: begin
                    if (w_load) begin
                        r_state <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (w_pop) begin
                        r_rem <= r_rem - 1'b1;
                        if (r_rem == 12'd1) begin
                            r_state <= ST_TRL;
                        end
                    end
                end
                ST_TRL: begin
                    // The frame only ends once the sink has actually taken the trailer.
                    if (w_push) begin
                        r_trl_sent <= 1'b1;
                    end else if (w_trl_acc) begin
                        r_trl_sent <= 1'b0;
                        r_busy     <= 1'b0;
                        r_state    <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_drop_cnt <= '0;
        end else if (trig && r_busy && (r_drop_cnt != 16'hFFFF)) begin
            r_drop_cnt <= r_drop_cnt + 16'd1;
        end
    end

`ifdef ADC_EVT_PACKER_CHKSUM_EN
    logic [CHK_W-1:0] r_chk;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_chk <= '0;
        end else if (r_state == ST_HDR) begin
            r_chk <= '0;
        end else if (w_pop) begin
            r_chk <= r_chk + {2'b00, fifo1_q} + {2'b00, fifo2_q};
        end
    end

    assign w_chk = r_chk;
`else
    assign w_chk = 16'h0000;
`endif

    adc_out_reg #(
        .W (WORD_W)
    ) u_out_reg (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_data  (w_word),
        .i_ready (out_ready),
        .o_valid (out_valid),
        .o_data  (out_data),
        .o_load  (w_load)
    );

endmodule
